// File: rtl/io_pkg.sv
// Shared definitions for the io_* port peripherals: UART FSM states and tx_status bit positions.
package io_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_t;

  localparam int ST_EMPTY = 0;
  localparam int ST_FULL  = 1;
  localparam int ST_BUSY  = 2;
  localparam int ST_OVF   = 3;

endpackage

// File: rtl/io_sync_fifo.sv
// Single-clock FIFO with registered pointers and count; a push is accepted while full
// when a pop happens on the same edge, so a streaming consumer never loses a slot.
module io_sync_fifo #(
  parameter int DW = 8,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic [DW-1:0] i_din,
  output logic [DW-1:0] o_dout,
  output logic          o_full,
  output logic          o_empty
);

  localparam int DEPTH = 2 ** AW;
  localparam logic [AW:0] DEPTH_CNT = DEPTH[AW:0];

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign o_full    = (r_count == DEPTH_CNT);
  assign o_empty   = (r_count == '0);
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);
  assign o_dout    = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/io_uart_tx.sv
// PicoBlaze output-port UART transmitter (8N1, or 8E1 when IO_UART_TX_PARITY_EN is defined)
// with a byte FIFO, sticky overflow flag and a pollable status word.
//
// state  | meaning
// IDLE   | line high, waiting for a queued byte
// START  | start bit (low)
// DATA   | 8 data bits, LSB first
// PARITY | even parity bit (IO_UART_TX_PARITY_EN only)
// STOP   | stop bit (high); pops the next byte at its end for back-to-back frames
module io_uart_tx
  import io_pkg::*;
#(
  parameter logic [7:0] DATA_ADDR = 8'h10,
  parameter logic [7:0] CTRL_ADDR = 8'h11,
  parameter int         CLK_DIV   = 434,
  parameter int         FIFO_AW   = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] address,
  input  logic [7:0] value_in,
  input  logic       wen,
  output logic       txd,
  output logic [7:0] tx_status
);

  localparam int BW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [BW-1:0] BAUD_MAX = BW'(CLK_DIV - 1);

  uart_state_t   r_state;
  logic [BW-1:0] r_baud;
  logic [2:0]    r_bit_cnt;
  logic [7:0]    r_shift;
  logic          r_txd;
  logic          r_ovf;
`ifdef IO_UART_TX_PARITY_EN
  logic          r_parity;
`endif

  logic       w_data_wr;
  logic       w_ctrl_clr;
  logic       w_bit_end;
  logic       w_pop;
  logic       w_push_rej;
  logic       w_full;
  logic       w_empty;
  logic [7:0] w_dout;
  logic       w_txd_nxt;
  logic [7:0] w_status;

  assign w_data_wr  = wen && (address == DATA_ADDR);
  assign w_ctrl_clr = wen && (address == CTRL_ADDR) && value_in[0];
  assign w_bit_end  = (r_baud == '0);
  assign w_pop      = !w_empty && ((r_state == IDLE) || ((r_state == STOP) && w_bit_end));
  assign w_push_rej = w_data_wr && w_full && !w_pop;

  io_sync_fifo #(
    .DW (8),
    .AW (FIFO_AW)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_data_wr),
    .i_pop   (w_pop),
    .i_din   (value_in),
    .o_dout  (w_dout),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // txd is the registered image of the current state, so the line lags the FSM by one cycle
  always_comb begin
    w_txd_nxt = 1'b1;
    case (r_state)
      START:   w_txd_nxt = 1'b0;
      DATA:    w_txd_nxt = r_shift[0];
`ifdef IO_UART_TX_PARITY_EN
      PARITY:  w_txd_nxt = r_parity;
`endif
      default: w_txd_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_baud    <= BAUD_MAX;
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_txd     <= 1'b1;
      r_ovf     <= 1'b0;
`ifdef IO_UART_TX_PARITY_EN
      r_parity  <= 1'b0;
`endif
    end else begin
      r_txd <= w_txd_nxt;

      if (w_push_rej)      r_ovf <= 1'b1;
      else if (w_ctrl_clr) r_ovf <= 1'b0;

      if (w_pop) begin
        r_state   <= START;
        r_shift   <= w_dout;
        r_baud    <= BAUD_MAX;
        r_bit_cnt <= '0;
`ifdef IO_UART_TX_PARITY_EN
        r_parity  <= ^w_dout;
`endif
      end else if (r_state != IDLE) begin
        if (w_bit_end) begin
          r_baud <= BAUD_MAX;
          case (r_state)
            START: r_state <= DATA;
            DATA: begin
              r_shift <= {1'b0, r_shift[7:1]};
              if (r_bit_cnt == 3'd7) begin
`ifdef IO_UART_TX_PARITY_EN
                r_state <= PARITY;
`else
                r_state <= STOP;
`endif
              end else begin
                r_bit_cnt <= r_bit_cnt + 1'b1;
              end
            end
`ifdef IO_UART_TX_PARITY_EN
            PARITY: r_state <= STOP;
`endif
            default: r_state <= IDLE;
          endcase
        end else begin
          r_baud <= r_baud - 1'b1;
        end
      end
    end
  end

  always_comb begin
    w_status           = '0;
    w_status[ST_EMPTY] = w_empty;
    w_status[ST_FULL]  = w_full;
    w_status[ST_BUSY]  = (r_state != IDLE);
    w_status[ST_OVF]   = r_ovf;
  end

  assign txd       = r_txd;
  assign tx_status = w_status;

endmodule
